// File: rtl/sound_player.sv
// Event-driven square-wave tone generator. A new sound code, or a hit strobe
// re-announcing the current code, starts a fixed-length tone at that code's pitch.
module sound_player #(
    parameter logic [19:0] HP1      = 20'd56818,
    parameter logic [19:0] HP2      = 20'd28409,
    parameter logic [19:0] HP3      = 20'd18939,
    parameter logic [19:0] HP4      = 20'd14205,
    parameter logic [23:0] DURATION = 24'd2500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] sound_code,
    input  logic       hit_strobe,
    input  logic       mute,
    output logic       speaker,
    output logic       busy,
    output logic [2:0] cur_code
);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t      state_q, state_d;
    logic [2:0]  last_code_q, last_code_d;
    logic [19:0] tone_cnt_q, tone_cnt_d;
    logic [23:0] dur_cnt_q, dur_cnt_d;
    logic [19:0] half_per_q, half_per_d;
    logic        wave_q, wave_d;
    logic [2:0]  cur_code_q, cur_code_d;

    logic [19:0] hp_sel;
    logic        code_valid;
    logic        trigger;

    always_comb begin
        hp_sel = HP1;
        case (sound_code)
            3'd1:    hp_sel = HP1;
            3'd2:    hp_sel = HP2;
            3'd3:    hp_sel = HP3;
            3'd4:    hp_sel = HP4;
            default: hp_sel = HP1;
        endcase
    end

    // Codes 0 and 5-7 are ignored entirely: they neither start nor stop a tone.
    assign code_valid = (sound_code >= 3'd1) && (sound_code <= 3'd4);
    assign trigger    = code_valid && ((sound_code != last_code_q) || hit_strobe);

    always_comb begin
        state_d     = state_q;
        last_code_d = sound_code;
        tone_cnt_d  = tone_cnt_q;
        dur_cnt_d   = dur_cnt_q;
        half_per_d  = half_per_q;
        wave_d      = wave_q;
        cur_code_d  = cur_code_q;

        if (trigger) begin
            // A trigger outranks expiry, so back-to-back tones never show an idle cycle.
            state_d    = PLAY;
            cur_code_d = sound_code;
            half_per_d = hp_sel;
            tone_cnt_d = hp_sel - 20'd1;
            dur_cnt_d  = DURATION - 24'd1;
            wave_d     = 1'b1;
        end else if (state_q == PLAY) begin
            if (tone_cnt_q == 20'd0) begin
                wave_d     = ~wave_q;
                tone_cnt_d = half_per_q - 20'd1;
            end else begin
                tone_cnt_d = tone_cnt_q - 20'd1;
            end
            if (dur_cnt_q == 24'd0) begin
                state_d    = IDLE;
                wave_d     = 1'b0;
                cur_code_d = 3'd0;
            end else begin
                dur_cnt_d = dur_cnt_q - 24'd1;
            end
        end else begin
            wave_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            last_code_q <= 3'd0;
            tone_cnt_q  <= 20'd0;
            dur_cnt_q   <= 24'd0;
            half_per_q  <= 20'd0;
            wave_q      <= 1'b0;
            cur_code_q  <= 3'd0;
        end else begin
            state_q     <= state_d;
            last_code_q <= last_code_d;
            tone_cnt_q  <= tone_cnt_d;
            dur_cnt_q   <= dur_cnt_d;
            half_per_q  <= half_per_d;
            wave_q      <= wave_d;
            cur_code_q  <= cur_code_d;
        end
    end

    assign speaker  = wave_q & ~mute;
    assign busy     = (state_q == PLAY);
    assign cur_code = cur_code_q;

endmodule

// File: doc/sound_player.md
# sound_player

Event-driven tone generator for the game's piezo/speaker output. Sits downstream of the ball physics block and consumes its 3-bit sound code and one-cycle hit strobe. Each new event starts a fixed-length square-wave tone whose pitch is selected by the code. It owns all audio timing, so the physics block only has to publish event codes.

## Interface
- `HP1`, default 20'd56818: half-period in clocks for code 1 (wall/ceiling, 220 Hz at 25 MHz).
- `HP2`, default 20'd28409: half-period for code 2 (block hit, first).
- `HP3`, default 20'd18939: half-period for code 3 (block hit, final).
- `HP4`, default 20'd14205: half-period for code 4 (paddle/floor).
- `DURATION`, default 24'd2500000: tone length in clocks (100 ms at 25 MHz); must be ≥1.
- `clk` input 1: system clock, all state on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `sound_code` input 3: event code from ball logic, level-held between events.
- `hit_strobe` input 1: one-cycle pulse (erase enable) that re-announces the current code.
- `mute` input 1: level; forces `speaker` low, timing unaffected.
- `speaker` output 1: square-wave audio.
- `busy` output 1: high while a tone is playing.
- `cur_code` output 3: code of the tone currently playing, 0 when idle.

## Operation
- Registers: `state` (IDLE/PLAY), `last_code[2:0]`, `tone_cnt[19:0]`, `dur_cnt[23:0]`, `half_per[19:0]`, `wave`, `cur_code`.
- `last_code <= sound_code` every cycle, including codes 0 and 5–7.
- Trigger when `(sound_code != last_code) || hit_strobe`, and only if `sound_code` is 1..4. A change to 0 or 5–7 is not a trigger and does not stop a playing tone.
- On trigger from any state:
  - state = PLAY; `cur_code` = `sound_code`; `half_per` = HPn.
  - `tone_cnt` = HPn-1; `dur_cnt` = DURATION-1; `wave` = 1.
- PLAY, no trigger:
  - If `tone_cnt` == 0: `wave` toggles and `tone_cnt` reloads `half_per`-1. Otherwise `tone_cnt` decrements.
  - If `dur_cnt` == 0: state = IDLE, `wave` = 0, `cur_code` = 0. Otherwise `dur_cnt` decrements.
- IDLE, no trigger: all counters hold; `wave` = 0.
- Outputs:
  - `speaker = wave & ~mute`
  - `busy = (state == PLAY)`
- Simultaneous events:
  - A trigger on the same edge as `dur_cnt` == 0 wins: the tone restarts and no IDLE cycle appears.
  - A retrigger with the same code restarts both duration and phase.
  - `hit_strobe` together with a code change counts as one trigger.
- Reset: asynchronous assertion forces state IDLE and all registers to 0. Outputs `speaker` = 0, `busy` = 0, `cur_code` = 0. A tone in progress is abandoned.
  - The first edge after release compares against `last_code` = 0. A nonzero valid `sound_code` held through reset therefore triggers one tone.
- Arithmetic is unsigned, using counter widths 20/24. HPn must be ≥1.

## Timing
- Trigger is sampled at edge N. From edge N, `busy` = 1, `speaker` = 1 (unmuted) and `cur_code` is valid.
- `speaker` is high for HPn cycles, then low for HPn cycles, repeating.
- `busy` stays high for exactly DURATION cycles, and falls at edge N+DURATION unless retriggered.
- `mute` is combinational to `speaker`, with zero-cycle effect.
- Steady state: there is no cycle in which PLAY is active with `speaker` undefined.

## Test plan
Parameters for all scenarios: HP1=2, HP2=3, HP3=4, HP4=5, DURATION=20.
- **Reset:** hold `sound_code`=0 through reset, then release. -> `speaker`, `busy` and `cur_code` are all 0, and stay 0 for 50 cycles.
- **Single tone:** `sound_code` 0 -> 1 at edge N. -> `busy` high for edges N..N+19. `speaker` pattern is 1,1,0,0 repeating. `cur_code` = 1, then 0 at N+20.
- **Retrigger and strobe:** code 4 at edge N, then `hit_strobe` at N+10 with code unchanged. -> `busy` remains high until N+30. The `speaker` phase restarts high at N+10 with period 10.
- **Code change mid-tone and invalid codes:**
  - Code 2 at N, then code 3 at N+5. -> `cur_code` = 3 from N+5, half-period becomes 4, `busy` ends at N+25.
  - Code 3 -> 0 at N+7. -> No effect; `busy` still ends at N+25.
  - Code 6 at any time. -> Never triggers.
- **Mute and expiry collision:**
  - `mute`=1 during a tone. -> `speaker` is 0 but `busy` and counters are unchanged.
  - A trigger at exactly edge N+20 of a prior tone. -> `busy` never drops.
- **Asynchronous reset mid-tone:** assert `reset` between edges at N+8 while `sound_code`=2. -> All outputs go to 0 immediately. After release, a tone with code 2 starts on the first edge.
